// File: rtl/rv64_pkg.sv
// Shared constants and types for the RV64I execute datapath.
package rv64_pkg;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASSB
   } alu_op_e;

   // Map funct3 plus the inst[30] "alternate" bit onto an ALU operation.
   // Immediate forms have no SUB, so allow_sub gates the ADD/SUB choice.
   function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       allow_sub);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv64_exec_datapath_if.sv
// Execute bus between the fetch state machine (master) and the datapath (slave).
// Handshake: exec_en is a one-cycle commit pulse with no back-pressure; the
// datapath always accepts, and wb_en/wb_rd/wb_data describe the write that
// lands on the rising edge that ends the exec_en cycle.
interface rv64_exec_datapath_if;
   import rv64_pkg::*;

   logic [31:0]      inst;
   logic [XLEN-1:0]  pc;
   logic             exec_en;
   logic             wb_en;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             illegal;
   logic             halt;

   modport master (
      output inst, pc, exec_en,
      input  wb_en, wb_rd, wb_data, illegal, halt
   );

   modport slave (
      input  inst, pc, exec_en,
      output wb_en, wb_rd, wb_data, illegal, halt
   );

endinterface

// File: rtl/rv64_regfile.sv
// 32 x 64 register file: two read ports, one debug read port, one write port.
// x0 always reads zero and ignores writes; reads do not bypass the write port.
module rv64_regfile
   import rv64_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs [NREGS];

   // Storage: asynchronous clear of every register, otherwise one write per edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Combinational reads straight from the array, x0 forced to zero.
   always_comb begin
      rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
      rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
      dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
   end

endmodule

// File: rtl/rv64_exec_datapath.sv
// Single-cycle RV64I integer execute datapath: decode, register file and ALU.
// All bus outputs are combinational from inst, pc and register contents.
module rv64_exec_datapath
   import rv64_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   rv64_exec_datapath_if.slave  bus,
   input  logic [4:0]           dbg_addr,
   output logic [XLEN-1:0]      dbg_data
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_u;
   logic [XLEN-1:0] rs1_data, rs2_data;

   logic            supported;
   logic            is_word;
   alu_op_e         alu_op;
   logic [XLEN-1:0] op_a, op_b;

   logic [XLEN-1:0] res64;
   logic [31:0]     res32;
   logic [XLEN-1:0] alu_result;

   assign opcode = bus.inst[6:0];
   assign funct3 = bus.inst[14:12];
   assign rs1    = bus.inst[19:15];
   assign rs2    = bus.inst[24:20];
   assign rd     = bus.inst[11:7];
   assign imm_i  = {{52{bus.inst[31]}}, bus.inst[31:20]};
   assign imm_u  = {{32{bus.inst[31]}}, bus.inst[31:12], 12'b0};

   rv64_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (bus.wb_en),
      .waddr    (rd),
      .wdata    (bus.wb_data)
   );

   // Decode: pick operands and ALU operation; W forms only define ADD/SLL/SR.
   always_comb begin
      supported = 1'b0;
      is_word   = 1'b0;
      alu_op    = ALU_ADD;
      op_a      = rs1_data;
      op_b      = imm_i;
      case (opcode)
         OPC_LUI: begin
            supported = 1'b1;
            op_b      = imm_u;
            alu_op    = ALU_PASSB;
         end
         OPC_AUIPC: begin
            supported = 1'b1;
            op_a      = bus.pc;
            op_b      = imm_u;
         end
         OPC_OP_IMM: begin
            supported = 1'b1;
            alu_op    = alu_op_from_f3(funct3, bus.inst[30], 1'b0);
         end
         OPC_OP: begin
            supported = 1'b1;
            op_b      = rs2_data;
            alu_op    = alu_op_from_f3(funct3, bus.inst[30], 1'b1);
         end
         OPC_OP_IMM32: begin
            supported = (funct3 == F3_ADD) || (funct3 == F3_SLL) || (funct3 == F3_SR);
            is_word   = 1'b1;
            alu_op    = alu_op_from_f3(funct3, bus.inst[30], 1'b0);
         end
         OPC_OP32: begin
            supported = (funct3 == F3_ADD) || (funct3 == F3_SLL) || (funct3 == F3_SR);
            is_word   = 1'b1;
            op_b      = rs2_data;
            alu_op    = alu_op_from_f3(funct3, bus.inst[30], 1'b1);
         end
         default: begin
            supported = 1'b0;
         end
      endcase
   end

   // ALU: 64-bit and 32-bit result paths; W results are sign-extended from bit 31.
   always_comb begin
      res64 = '0;
      res32 = '0;
      case (alu_op)
         ALU_ADD:   res64 = op_a + op_b;
         ALU_SUB:   res64 = op_a - op_b;
         ALU_SLL:   res64 = op_a << op_b[5:0];
         ALU_SLT:   res64 = {63'b0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:  res64 = {63'b0, op_a < op_b};
         ALU_XOR:   res64 = op_a ^ op_b;
         ALU_SRL:   res64 = op_a >> op_b[5:0];
         ALU_SRA:   res64 = $signed(op_a) >>> op_b[5:0];
         ALU_OR:    res64 = op_a | op_b;
         ALU_AND:   res64 = op_a & op_b;
         ALU_PASSB: res64 = op_b;
         default:   res64 = '0;
      endcase
      case (alu_op)
         ALU_ADD: res32 = op_a[31:0] + op_b[31:0];
         ALU_SUB: res32 = op_a[31:0] - op_b[31:0];
         ALU_SLL: res32 = op_a[31:0] << op_b[4:0];
         ALU_SRL: res32 = op_a[31:0] >> op_b[4:0];
         ALU_SRA: res32 = $signed(op_a[31:0]) >>> op_b[4:0];
         default: res32 = '0;
      endcase
      alu_result = is_word ? {{32{res32[31]}}, res32} : res64;
   end

   // Writeback and status: an all-zero word is a halt, never an illegal opcode.
   always_comb begin
      bus.halt    = (bus.inst == 32'h0);
      bus.illegal = !supported && !bus.halt;
      bus.wb_rd   = rd;
      bus.wb_data = supported ? alu_result : '0;
      bus.wb_en   = bus.exec_en && supported && (rd != 5'd0);
   end

endmodule

// File: tb/tb_rv64_exec_datapath.sv
// Self-checking bench for rv64_exec_datapath with an instruction-level model.
module tb_rv64_exec_datapath;
  import rv64_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  rv64_exec_datapath_if bus ();

  rv64_exec_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int checks = 0;
  int passes = 0;

  logic [63:0] model_regs [32];
  logic [63:0] exp_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] mreg(input logic [4:0] idx);
    return (idx == 5'd0) ? 64'd0 : model_regs[idx];
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Returns {valid, value} for one instruction at architectural level.
  function automatic logic [64:0] ref_exec(input logic [31:0] ins, input logic [63:0] p);
    logic [63:0] a, b, ii, iu, v;
    logic [31:0] w;
    logic ok;
    a  = mreg(ins[19:15]);
    b  = mreg(ins[24:20]);
    ii = {{52{ins[31]}}, ins[31:20]};
    iu = sx32({ins[31:12], 12'h000});
    ok = 1'b1;
    v  = 64'd0;
    w  = 32'd0;
    case (ins[6:0])
      7'b0110111: v = iu;
      7'b0010111: v = p + iu;
      7'b0010011: case (ins[14:12])
        3'd0: v = a + ii;
        3'd1: v = a << ins[25:20];
        3'd2: v = ($signed(a) < $signed(ii)) ? 64'd1 : 64'd0;
        3'd3: v = (a < ii) ? 64'd1 : 64'd0;
        3'd4: v = a ^ ii;
        3'd5: v = ins[30] ? 64'($signed(a) >>> ins[25:20]) : (a >> ins[25:20]);
        3'd6: v = a | ii;
        default: v = a & ii;
      endcase
      7'b0110011: case (ins[14:12])
        3'd0: v = ins[30] ? a - b : a + b;
        3'd1: v = a << b[5:0];
        3'd2: v = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        3'd3: v = (a < b) ? 64'd1 : 64'd0;
        3'd4: v = a ^ b;
        3'd5: v = ins[30] ? 64'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
        3'd6: v = a | b;
        default: v = a & b;
      endcase
      7'b0011011: begin
        case (ins[14:12])
          3'd0: w = a[31:0] + ii[31:0];
          3'd1: w = a[31:0] << ins[24:20];
          3'd5: w = ins[30] ? 32'($signed(a[31:0]) >>> ins[24:20]) : (a[31:0] >> ins[24:20]);
          default: ok = 1'b0;
        endcase
        v = ok ? sx32(w) : 64'd0;
      end
      7'b0111011: begin
        case (ins[14:12])
          3'd0: w = ins[30] ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
          3'd1: w = a[31:0] << b[4:0];
          3'd5: w = ins[30] ? 32'($signed(a[31:0]) >>> b[4:0]) : (a[31:0] >> b[4:0]);
          default: ok = 1'b0;
        endcase
        v = ok ? sx32(w) : 64'd0;
      end
      default: ok = 1'b0;
    endcase
    return {ok, v};
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, opc};
  endfunction

  // ---------------- driver ----------------
  task automatic run_inst(input logic [31:0] ins, input logic [63:0] p, input string tag);
    logic [64:0] r;
    logic [4:0]  rd;
    logic        exp_en;
    logic [63:0] exp_data;
    @(negedge clk);
    bus.inst    = ins;
    bus.pc      = p;
    bus.exec_en = 1'b1;
    r      = ref_exec(ins, p);
    rd     = ins[11:7];
    exp_en = r[64] && (rd != 5'd0);
    exp_q.push_back(r[64] ? r[63:0] : 64'd0);
    #1;
    checks++;
    if (bus.halt !== (ins == 32'h0))
      $display("FAIL %s halt: got %0b expected %0b", tag, bus.halt, (ins == 32'h0));
    else passes++;
    checks++;
    if (bus.illegal !== (!r[64] && ins != 32'h0))
      $display("FAIL %s illegal: got %0b expected %0b", tag, bus.illegal, (!r[64] && ins != 32'h0));
    else passes++;
    checks++;
    if (bus.wb_en !== exp_en)
      $display("FAIL %s wb_en: got %0b expected %0b", tag, bus.wb_en, exp_en);
    else passes++;
    exp_data = exp_q.pop_front();
    checks++;
    if (bus.wb_data !== exp_data)
      $display("FAIL %s wb_data: got %h expected %h", tag, bus.wb_data, exp_data);
    else passes++;
    if (exp_en) begin
      checks++;
      if (bus.wb_rd !== rd)
        $display("FAIL %s wb_rd: got %0d expected %0d", tag, bus.wb_rd, rd);
      else passes++;
    end
    @(posedge clk);
    #1;
    bus.exec_en = 1'b0;
    if (exp_en) model_regs[rd] = r[63:0];
  endtask

  task automatic read_dbg(input logic [4:0] idx, output logic [63:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] v;
    reset = 1'b0;
    bus.inst = 32'h0;
    bus.pc = 64'd0;
    bus.exec_en = 1'b0;
    dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    #12;
    checks++;
    if (bus.halt !== 1'b1) $display("FAIL reset_halt: got %0b expected 1", bus.halt);
    else passes++;
    for (int i = 0; i < 32; i += 7) begin
      read_dbg(5'(i), v);
      checks++;
      if (v !== 64'd0) $display("FAIL reset_reg%0d: got %h expected 0", i, v);
      else passes++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_addi();
    logic [63:0] v;
    run_inst(32'h00500093, 64'h0, "addi_x1");
    read_dbg(5'd1, v);
    checks++;
    if (v !== 64'd5) $display("FAIL addi_x1_dbg: got %h expected 5", v);
    else passes++;
  endtask

  task automatic test_x0();
    logic [63:0] v;
    run_inst(32'h00700013, 64'h0, "addi_x0");
    read_dbg(5'd0, v);
    checks++;
    if (v !== 64'd0) $display("FAIL x0_dbg: got %h expected 0", v);
    else passes++;
  endtask

  task automatic test_lui_auipc();
    logic [63:0] v;
    run_inst(32'h12345137, 64'h0, "lui_x2");
    run_inst(32'h00001197, 64'h1000, "auipc_x3");
    read_dbg(5'd2, v);
    checks++;
    if (v !== 64'h0000000012345000) $display("FAIL lui_dbg: got %h expected 0000000012345000", v);
    else passes++;
    read_dbg(5'd3, v);
    checks++;
    if (v !== 64'h2000) $display("FAIL auipc_dbg: got %h expected 2000", v);
    else passes++;
  endtask

  task automatic test_addiw();
    logic [63:0] v;
    run_inst(enc_u(OPC_LUI, 5'd1, 20'h80000), 64'h0, "lui_x1");
    run_inst(enc_i(OPC_OP_IMM32, F3_ADD, 5'd1, 5'd1, 12'hFFF), 64'h0, "addiw_x1");
    read_dbg(5'd1, v);
    checks++;
    if (v !== 64'h000000007FFFFFFF) $display("FAIL x1_max32: got %h expected 000000007fffffff", v);
    else passes++;
    run_inst(enc_i(OPC_OP_IMM32, F3_ADD, 5'd4, 5'd1, 12'h001), 64'h0, "addiw_x4");
    read_dbg(5'd4, v);
    checks++;
    if (v !== 64'hFFFFFFFF80000000) $display("FAIL addiw_wrap: got %h expected ffffffff80000000", v);
    else passes++;
  endtask

  task automatic test_shifts();
    logic [63:0] v;
    run_inst(enc_i(OPC_OP_IMM, F3_ADD, 5'd5, 5'd0, 12'hFF0), 64'h0, "addi_x5");
    run_inst(enc_i(OPC_OP_IMM, F3_SR, 5'd6, 5'd5, 12'h402), 64'h0, "srai_x6");
    run_inst(enc_i(OPC_OP_IMM, F3_SR, 5'd7, 5'd5, 12'h03C), 64'h0, "srli_x7");
    run_inst(enc_i(OPC_OP_IMM, F3_ADD, 5'd9, 5'd0, 12'hFFF), 64'h0, "addi_x9");
    run_inst(enc_i(OPC_OP_IMM, F3_ADD, 5'd10, 5'd0, 12'h001), 64'h0, "addi_x10");
    run_inst(enc_r(OPC_OP, F3_SLTU, 7'h00, 5'd8, 5'd9, 5'd10), 64'h0, "sltu_x8");
    read_dbg(5'd6, v);
    checks++;
    if (v !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL srai_dbg: got %h expected fffffffffffffffc", v);
    else passes++;
    read_dbg(5'd7, v);
    checks++;
    if (v !== 64'hF) $display("FAIL srli_dbg: got %h expected f", v);
    else passes++;
    read_dbg(5'd8, v);
    checks++;
    if (v !== 64'd0) $display("FAIL sltu_dbg: got %h expected 0", v);
    else passes++;
  endtask

  task automatic test_halt_illegal();
    logic [63:0] v;
    run_inst(32'h00000000, 64'h0, "halt");
    run_inst(32'h000000EF, 64'h40, "jal_x1");
    read_dbg(5'd1, v);
    checks++;
    if (v !== 64'h000000007FFFFFFF) $display("FAIL jal_nowrite: got %h expected 000000007fffffff", v);
    else passes++;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic        alt;
    logic [6:0]  bad [4];
    bad[0] = 7'b1101111; bad[1] = 7'b1100011; bad[2] = 7'b0000011; bad[3] = 7'b0100011;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    alt = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: return enc_u(OPC_LUI, rd, 20'($urandom));
      1: return enc_u(OPC_AUIPC, rd, 20'($urandom));
      2: begin
        if (f3 == F3_SLL) imm = {6'b0, imm[5:0]};
        if (f3 == F3_SR)  imm = {1'b0, alt, 4'b0, imm[5:0]};
        return enc_i(OPC_OP_IMM, f3, rd, rs1, imm);
      end
      3: return enc_r(OPC_OP, f3, {1'b0, alt && (f3 == F3_ADD || f3 == F3_SR), 5'b0}, rd, rs1, rs2);
      4: begin
        f3 = (f3 < 3) ? F3_ADD : (f3 < 5) ? F3_SLL : F3_SR;
        if (f3 != F3_ADD) imm = {1'b0, alt && (f3 == F3_SR), 5'b0, imm[4:0]};
        return enc_i(OPC_OP_IMM32, f3, rd, rs1, imm);
      end
      5: begin
        f3 = (f3 < 3) ? F3_ADD : (f3 < 5) ? F3_SLL : F3_SR;
        return enc_r(OPC_OP32, f3, {1'b0, alt && (f3 != F3_SLL), 5'b0}, rd, rs1, rs2);
      end
      default: return {25'($urandom), bad[$urandom_range(0, 3)]};
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] v;
    for (int r = 1; r < 32; r++) begin
      run_inst(enc_u(OPC_LUI, 5'(r), 20'($urandom)), 64'h0, "seed_lui");
      run_inst(enc_i(OPC_OP_IMM, F3_ADD, 5'(r), 5'(r), 12'($urandom)), 64'h0, "seed_addi");
    end
    for (int n = 0; n < 300; n++) begin
      run_inst(rand_inst(), {$urandom, $urandom}, "rand");
    end
    for (int r = 0; r < 32; r++) begin
      read_dbg(5'(r), v);
      checks++;
      if (v !== mreg(5'(r))) $display("FAIL dump_x%0d: got %h expected %h", r, v, mreg(5'(r)));
      else passes++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] v;
    @(negedge clk);
    bus.inst    = 32'h06300093;
    bus.exec_en = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.exec_en = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    for (int r = 0; r < 32; r++) begin
      read_dbg(5'(r), v);
      checks++;
      if (v !== 64'd0) $display("FAIL midreset_x%0d: got %h expected 0", r, v);
      else passes++;
    end
    @(negedge clk);
    reset = 1'b1;
    run_inst(32'h00500093, 64'h0, "post_reset_addi");
    read_dbg(5'd1, v);
    checks++;
    if (v !== 64'd5) $display("FAIL post_reset_x1: got %h expected 5", v);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_x0();
    test_lui_auipc();
    test_addiw();
    test_shifts();
    test_halt_illegal();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
